sargantana_icache_way_alloc: RTL and testbench

//  Refill-side way allocator for the instruction cache: the converse of the hit-side way encoder.
//  On a miss, takes the set index and that set's valid bits and returns the victim way as both an index and a one-hot write-enable.

---
 rtl/sargantana_icache_way_alloc.sv | 119 +++++++++++
 tb/tb_sargantana_icache_way_alloc.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sargantana_icache_way_alloc.sv
// Refill-side victim-way allocator for the instruction cache: first invalid way, else tree-PLRU,
// with per-set 3-bit PLRU state touched by cache hits and by acknowledged refills.
module sargantana_icache_way_alloc #(
  parameter  int ICACHE_N_WAY  = 4,
  parameter  int ICACHE_N_SETS = 64,
  localparam int SET_W         = $clog2(ICACHE_N_SETS)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    hit_valid_i,
  input  logic [SET_W-1:0]        hit_set_i,
  input  logic [ICACHE_N_WAY-1:0] hit_way_i,
  input  logic                    alloc_req_i,
  input  logic [SET_W-1:0]        alloc_set_i,
  input  logic [ICACHE_N_WAY-1:0] valid_bits_i,
  output logic                    alloc_ready_o,
  output logic                    alloc_valid_o,
  output logic [ICACHE_N_WAY-1:0] alloc_way_o,
  output logic [1:0]              alloc_idx_o,
  input  logic                    alloc_ack_i
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t                        state_reg, state_next;
  logic                          capture;
  logic [ICACHE_N_SETS-1:0][2:0] plru_reg, plru_next;
  logic [ICACHE_N_WAY-1:0]       way_reg;
  logic [1:0]                    idx_reg;
  logic [SET_W-1:0]              set_reg;
  logic [2:0]                    cur_bits;
  logic [1:0]                    victim_idx;
  logic [1:0]                    hit_idx;
  logic                          hit_en;
  logic                          ack_en;

  // Point the tree bits away from the touched way; untouched subtree bit is kept.
  function automatic logic [2:0] touch(input logic [2:0] bits, input logic [1:0] way);
    logic [2:0] r;
    r = bits;
    case (way)
      2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
      2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
      2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
      default: begin r[0] = 1'b0; r[2] = 1'b0; end
    endcase
    return r;
  endfunction

  // Victim selection reads the pre-update PLRU state, so a same-cycle hit cannot steer it.
  always_comb begin
    cur_bits   = plru_reg[alloc_set_i];
    victim_idx = cur_bits[0] ? (cur_bits[2] ? 2'd3 : 2'd2) : (cur_bits[1] ? 2'd1 : 2'd0);
    for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
      if (!valid_bits_i[i]) victim_idx = 2'(i);
    end
  end

  always_comb begin
    hit_idx = 2'd0;
    for (int i = ICACHE_N_WAY - 1; i >= 0; i--) begin
      if (hit_way_i[i]) hit_idx = 2'(i);
    end
  end

  assign hit_en = hit_valid_i && (|hit_way_i);
  assign ack_en = (state_reg == RESP) && alloc_ack_i;

  // Hit touch first, then ack touch, so the ack wins on bits both write.
  for (genvar gi = 0; gi < ICACHE_N_SETS; gi++) begin : g_set
    logic [2:0] after_hit;
    assign after_hit     = (hit_en && hit_set_i == SET_W'(gi)) ? touch(plru_reg[gi], hit_idx)
                                                               : plru_reg[gi];
    assign plru_next[gi] = (ack_en && set_reg == SET_W'(gi)) ? touch(after_hit, idx_reg)
                                                             : after_hit;
  end

  always_comb begin
    state_next = state_reg;
    capture    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (alloc_req_i) begin
          capture    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (alloc_ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_reg <= IDLE;
      plru_reg  <= '0;
      way_reg   <= '0;
      idx_reg   <= '0;
      set_reg   <= '0;
    end else begin
      state_reg <= state_next;
      plru_reg  <= plru_next;
      if (capture) begin
        way_reg <= ICACHE_N_WAY'(1) << victim_idx;
        idx_reg <= victim_idx;
        set_reg <= alloc_set_i;
      end
    end
  end

  assign alloc_ready_o = (state_reg == IDLE);
  assign alloc_valid_o = (state_reg == RESP);
  assign alloc_way_o   = way_reg;
  assign alloc_idx_o   = idx_reg;

endmodule

// File: tb/tb_sargantana_icache_way_alloc.sv
// Scoreboard bench for the icache way allocator: stimulus queues expected victims,
// a negedge monitor pops and checks them when alloc_valid_o rises.
module tb_sargantana_icache_way_alloc;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       flush_i = 1'b0;
  logic       hit_valid_i = 1'b0;
  logic [5:0] hit_set_i = '0;
  logic [3:0] hit_way_i = '0;
  logic       alloc_req_i = 1'b0;
  logic [5:0] alloc_set_i = '0;
  logic [3:0] valid_bits_i = '0;
  logic       alloc_ready_o;
  logic       alloc_valid_o;
  logic [3:0] alloc_way_o;
  logic [1:0] alloc_idx_o;
  logic       alloc_ack_i = 1'b0;

  sargantana_icache_way_alloc dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .hit_valid_i(hit_valid_i), .hit_set_i(hit_set_i), .hit_way_i(hit_way_i),
    .alloc_req_i(alloc_req_i), .alloc_set_i(alloc_set_i), .valid_bits_i(valid_bits_i),
    .alloc_ready_o(alloc_ready_o), .alloc_valid_o(alloc_valid_o),
    .alloc_way_o(alloc_way_o), .alloc_idx_o(alloc_idx_o), .alloc_ack_i(alloc_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] way;
    logic [1:0] idx;
    int         cyc;
    logic [5:0] set;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: each rising edge of alloc_valid_o must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (alloc_valid_o && !prev_valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_victim: got way=%b idx=%0d, required no response", alloc_way_o, alloc_idx_o);
        end else begin
          e = sb.pop_front();
          if (alloc_way_o !== e.way || alloc_idx_o !== e.idx || cyc != e.cyc) begin
            errors++;
            $display("FAIL victim_set%0d: got way=%b idx=%0d cyc=%0d, required way=%b idx=%0d cyc=%0d",
                     e.set, alloc_way_o, alloc_idx_o, cyc, e.way, e.idx, e.cyc);
          end else begin
            $display("alloc set=%0d way=%b idx=%0d cyc=%0d", e.set, alloc_way_o, alloc_idx_o, cyc);
          end
        end
      end
      prev_valid = alloc_valid_o;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic alloc(input logic [5:0] s, input logic [3:0] v, input logic [1:0] ei);
    exp_t e;
    int   n = 0;
    while (!alloc_ready_o && n < 20) begin
      step();
      n++;
    end
    chk("ready_before_req", alloc_ready_o, 1);
    alloc_req_i  = 1'b1;
    alloc_set_i  = s;
    valid_bits_i = v;
    e.way = 4'b0001 << ei;
    e.idx = ei;
    e.cyc = cyc + 1;
    e.set = s;
    sb.push_back(e);
    step();
    alloc_req_i  = 1'b0;
    valid_bits_i = '0;
  endtask

  task automatic ack();
    alloc_ack_i = 1'b1;
    step();
    alloc_ack_i = 1'b0;
  endtask

  task automatic hit(input logic [5:0] s, input logic [3:0] w);
    hit_valid_i = 1'b1;
    hit_set_i   = s;
    hit_way_i   = w;
    step();
    hit_valid_i = 1'b0;
    hit_way_i   = '0;
  endtask

  initial begin
    do_reset();
    chk("reset_ready", alloc_ready_o, 1);
    chk("reset_valid", alloc_valid_o, 0);
    chk("reset_way", alloc_way_o, 0);
    chk("reset_idx", alloc_idx_o, 0);

    // Empty set: way 0; request in RESP is ignored; ready stays low until the ack.
    alloc(6'd5, 4'b0000, 2'd0);
    chk("resp_ready_low", alloc_ready_o, 0);
    alloc_req_i = 1'b1; alloc_set_i = 6'd5; valid_bits_i = 4'b1111;
    step();
    alloc_req_i = 1'b0; valid_bits_i = '0;
    chk("resp_req_ignored_way", alloc_way_o, 4'b0001);
    chk("resp_still_valid", alloc_valid_o, 1);
    chk("resp_ready_still_low", alloc_ready_o, 0);
    ack();
    chk("post_ack_ready", alloc_ready_o, 1);
    chk("post_ack_valid", alloc_valid_o, 0);

    // First invalid way; touching w2 from 000 gives 100 -> next victims w0, then w3.
    do_reset();
    alloc(6'd5, 4'b1011, 2'd2); ack();
    alloc(6'd5, 4'b1111, 2'd0); ack();
    alloc(6'd5, 4'b1111, 2'd3); ack();
    alloc(6'd10, 4'b0101, 2'd1); ack();
    alloc(6'd10, 4'b0111, 2'd3); ack();

    // All-valid PLRU sequence on set 3.
    do_reset();
    alloc(6'd3, 4'b1111, 2'd0); ack();
    alloc(6'd3, 4'b1111, 2'd2); ack();
    alloc(6'd3, 4'b1111, 2'd1); ack();

    // Hit in RESP leaves the latched victim alone; PLRU = touch w1 then w0 = 011 -> w2.
    do_reset();
    alloc(6'd3, 4'b1111, 2'd0);
    hit(6'd3, 4'b0010);
    chk("hit_in_resp_way", alloc_way_o, 4'b0001);
    chk("hit_in_resp_idx", alloc_idx_o, 0);
    ack();
    alloc(6'd3, 4'b1111, 2'd2); ack();

    // Same-cycle hit w3 and ack w0 on set 7: 000 -> 000 -> 011 -> victim w2.
    do_reset();
    alloc(6'd7, 4'b1111, 2'd0);
    hit_valid_i = 1'b1; hit_set_i = 6'd7; hit_way_i = 4'b1000;
    ack();
    hit_valid_i = 1'b0; hit_way_i = '0;
    alloc(6'd7, 4'b1111, 2'd2); ack();

    // Zero hit way: no update. Multi-hot 0110 touches w1: 011 -> 001 -> victim w2.
    do_reset();
    hit(6'd2, 4'b0000);
    alloc(6'd2, 4'b1111, 2'd0); ack();
    hit(6'd2, 4'b0110);
    alloc(6'd2, 4'b1111, 2'd2); ack();

    // Hit with an accepted request to the same set: victim from pre-update state.
    hit_valid_i = 1'b1; hit_set_i = 6'd4; hit_way_i = 4'b0001;
    alloc(6'd4, 4'b1111, 2'd0);
    hit_valid_i = 1'b0; hit_way_i = '0;
    ack();
    alloc(6'd4, 4'b1111, 2'd2); ack();

    // Flush in RESP drops the allocation and clears PLRU.
    do_reset();
    alloc(6'd9, 4'b1111, 2'd0); ack();
    alloc(6'd9, 4'b1111, 2'd2);
    flush_i = 1'b1; alloc_ack_i = 1'b1;
    step();
    flush_i = 1'b0; alloc_ack_i = 1'b0;
    chk("flush_valid", alloc_valid_o, 0);
    chk("flush_ready", alloc_ready_o, 1);
    alloc(6'd9, 4'b1111, 2'd0); ack();
    alloc(6'd2, 4'b1111, 2'd0); ack();

    // Reset mid-RESP behaves like flush.
    alloc(6'd9, 4'b1111, 2'd2);
    do_reset();
    chk("rst_valid", alloc_valid_o, 0);
    chk("rst_ready", alloc_ready_o, 1);
    alloc(6'd9, 4'b1111, 2'd0); ack();

    repeat (3) step();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
